// File: rtl/ps2_scancode_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_scancode_ctrl_if
//   Groups the signals between the PS/2 byte receiver, the scan-code
//   sequencer and the CPU/MMIO event consumer.
//   Receive side : BYTE_VALID, BYTE, BYTE_ERR      (receiver -> sequencer)
//   Event side   : EV_VALID, EV_CODE, EV_BREAK,
//                  EV_EXT                          (sequencer -> consumer)
//                  EV_READY                        (consumer -> sequencer)
//   slave  modport: the sequencer's view.
//   master modport: the environment's view (receiver plus consumer).
// ---------------------------------------------------------------------------
interface ps2_scancode_ctrl_if;
  logic       BYTE_VALID;
  logic [7:0] BYTE;
  logic       BYTE_ERR;
  logic       EV_READY;
  logic       EV_VALID;
  logic [7:0] EV_CODE;
  logic       EV_BREAK;
  logic       EV_EXT;

  modport slave (
    input  BYTE_VALID, BYTE, BYTE_ERR, EV_READY,
    output EV_VALID, EV_CODE, EV_BREAK, EV_EXT
  );

  modport master (
    output BYTE_VALID, BYTE, BYTE_ERR, EV_READY,
    input  EV_VALID, EV_CODE, EV_BREAK, EV_EXT
  );
endinterface

// File: rtl/ps2_scancode_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_scancode_ctrl
//   Turns the PS/2 receive byte stream into key events. The E0 (extended),
//   F0 (break) and E1 (Pause) prefixes are tracked, and keyboard protocol
//   bytes are dropped. Each event {break, ext, code} is queued in a small
//   FIFO that the consumer drains over a valid/ready handshake.
// Ports
//   CLK       : system clock
//   RST_N     : synchronous active-low reset
//   bus       : receive bytes in, events out (ps2_scancode_ctrl_if.slave)
//   CLR_FLAGS : 1-cycle pulse that clears OVERFLOW and RX_ERR
//   OVERFLOW  : sticky, an event was dropped because the FIFO was full
//   RX_ERR    : sticky, an errored byte arrived or a prefix timed out
// ---------------------------------------------------------------------------
module ps2_scancode_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  ps2_scancode_ctrl_if.slave       bus,
  input  logic                     CLR_FLAGS,
  output logic                     OVERFLOW,
  output logic                     RX_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_E0   = 3'd1;
  localparam logic [2:0] S_F0   = 3'd2;
  localparam logic [2:0] S_E0F0 = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  // Bytes the keyboard sends for protocol purposes (BAT, ACK, resend, echo, errors).
  function automatic logic is_proto(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  logic [2:0]    state, state_nxt;
  logic [2:0]    skip_cnt, skip_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          push, err_set;
  logic [9:0]    push_ev;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count;
  logic [9:0]    head_q, head_nxt;
  logic          full, empty, do_push, do_pop, ovf_set;
  logic          byte_ok, byte_bad;

  assign byte_ok  = bus.BYTE_VALID & ~bus.BYTE_ERR;
  assign byte_bad = bus.BYTE_VALID &  bus.BYTE_ERR;

  // Prefix sequencer
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    timer_nxt = timer;
    push      = 1'b0;
    push_ev   = '0;
    err_set   = 1'b0;
    if (byte_bad) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
      err_set   = 1'b1;
    end else if (byte_ok) begin
      timer_nxt = '0;
      case (state)
        S_IDLE: begin
          if (bus.BYTE == 8'hE0)      state_nxt = S_E0;
          else if (bus.BYTE == 8'hF0) state_nxt = S_F0;
          else if (bus.BYTE == 8'hE1) begin
            // Pause: E1 is followed by 7 more bytes that carry no information.
            state_nxt = S_SKIP;
            skip_nxt  = 3'd7;
          end else if (!is_proto(bus.BYTE)) begin
            push    = 1'b1;
            push_ev = {2'b00, bus.BYTE};
          end
        end
        S_E0: begin
          if (bus.BYTE == 8'hF0) state_nxt = S_E0F0;
          else begin
            // E0 12 is the fake-shift wrapper some keys emit; it is not a key.
            state_nxt = S_IDLE;
            if (bus.BYTE != 8'h12) begin
              push    = 1'b1;
              push_ev = {2'b01, bus.BYTE};
            end
          end
        end
        S_F0: begin
          state_nxt = S_IDLE;
          push      = 1'b1;
          push_ev   = {2'b10, bus.BYTE};
        end
        S_E0F0: begin
          state_nxt = S_IDLE;
          if (bus.BYTE != 8'h12) begin
            push    = 1'b1;
            push_ev = {2'b11, bus.BYTE};
          end
        end
        S_SKIP: begin
          if (skip_cnt == 3'd1) begin
            state_nxt = S_IDLE;
            skip_nxt  = 3'd0;
            push      = 1'b1;
            push_ev   = {2'b01, 8'hE1};
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      // Abandon a prefix that waited TIMEOUT_CYC cycles without a byte.
      if (timer == TW'(TIMEOUT_CYC - 1)) begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
        err_set   = 1'b1;
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end
  end

  // Event FIFO control
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = ~empty & bus.EV_READY;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;
  assign rd_nxt  = rd_ptr + 1'b1;

  // Head register: keeps the last event visible after the FIFO drains.
  always_comb begin
    head_nxt = head_q;
    if (do_pop) begin
      if (count > CW'(1)) head_nxt = mem[rd_nxt];
      else if (do_push)   head_nxt = push_ev;
    end else if (empty && do_push) begin
      head_nxt = push_ev;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  // Stage boundary: sequencer state, FIFO pointers, head and flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      timer    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_q   <= '0;
      OVERFLOW <= 1'b0;
      RX_ERR   <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      timer    <= timer_nxt;
      head_q   <= head_nxt;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      OVERFLOW <= ovf_set | (OVERFLOW & ~CLR_FLAGS);
      RX_ERR   <= err_set | (RX_ERR & ~CLR_FLAGS);
    end
  end

  assign bus.EV_VALID = ~empty;
  assign {bus.EV_BREAK, bus.EV_EXT, bus.EV_CODE} = head_q;

endmodule
